// File: rtl/ysyx_24100029_wb_scheduler_pkg.sv
// Shared constants for the writeback scheduler slice: GPR geometry, the
// hardwired-zero register index and the round-robin pointer step helper.
package ysyx_24100029_pkg;

  localparam int GPR_ADDR_W = 4;
  localparam int XLEN       = 32;
  localparam logic [GPR_ADDR_W-1:0] REG_ZERO = '0;
  localparam int NUM_WB_REQ = 2;

  // Next first-priority index after index idx has been served among n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/ysyx_24100029_wb_scheduler_if.sv
// Writeback request bundle between the execution units (master side) and
// the writeback scheduler (slave side). Requester i occupies slice i of the
// packed address and data vectors.
interface ysyx_24100029_wb_scheduler_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);

endinterface

// File: rtl/ysyx_24100029_rr_arbiter.sv
// Round-robin arbiter: grants the first requesting index at or after the
// priority pointer (wrapping), and moves the pointer just past the winner
// whenever the grant is accepted.
module ysyx_24100029_rr_arbiter
  import ysyx_24100029_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  logic [IDX_W-1:0] ptr;
  int               cand;

  // Search requesters starting at the pointer and pick the first one asking.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!grant_valid && req[IDX_W'(cand)]) begin
        grant_valid            = 1'b1;
        grant[IDX_W'(cand)]    = 1'b1;
        grant_idx              = IDX_W'(cand);
      end
    end
  end

  // Pointer advances past the winner only when the grant is actually taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
    end else if (accept && grant_valid) begin
      ptr <= IDX_W'(rr_next(int'(grant_idx), NUM_REQ));
    end
  end

endmodule

// File: rtl/ysyx_24100029_wb_scheduler.sv
// Writeback scheduler: arbitrates the execution units onto the single
// register-file write port (one registered write stage) and keeps the
// per-register pending-write scoreboard used by the decoder for RAW stalls.
module ysyx_24100029_wb_scheduler
  import ysyx_24100029_pkg::*;
#(
  parameter int ADDR_WIDTH = GPR_ADDR_W,
  parameter int DATA_WIDTH = XLEN,
  parameter int NUM_REQ    = NUM_WB_REQ,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  ysyx_24100029_wb_scheduler_if.slave wb,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  output logic                       issue_ready,
  input  logic [ADDR_WIDTH-1:0]      rs1_addr,
  input  logic [ADDR_WIDTH-1:0]      rs2_addr,
  output logic                       rs1_busy,
  output logic                       rs2_busy,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [2**ADDR_WIDTH-1:0]   busy_mask
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

  logic [NUM_REQ-1:0]       grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_valid;
  logic                     handshake;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic                     issue_fire;
  logic [2**ADDR_WIDTH-1:0] busy_next;

  ysyx_24100029_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clock       (clock),
    .reset       (reset),
    .req         (wb.req_valid),
    .accept      (handshake),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign wb.req_ready = grant;
  assign handshake    = grant_valid && |(wb.req_valid & grant);
  assign sel_addr     = wb.req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data     = wb.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

  // x0 never has a pending write, and a set bit blocks reissue until committed.
  assign issue_ready = !busy_mask[issue_rd] || (issue_rd == ZERO_IDX);
  assign issue_fire  = issue_valid && issue_ready;
  assign rs1_busy    = busy_mask[rs1_addr] && (rs1_addr != ZERO_IDX);
  assign rs2_busy    = busy_mask[rs2_addr] && (rs2_addr != ZERO_IDX);

  // Write stage: register the winner; writes to x0 are swallowed here.
  always_ff @(posedge clock) begin
    if (reset) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wen <= handshake && (sel_addr != ZERO_IDX);
      if (handshake) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

  // Scoreboard next state: issue sets, commit clears, and the clear is applied last.
  always_comb begin
    busy_next = busy_mask;
    if (issue_fire && (issue_rd != ZERO_IDX)) begin
      busy_next[issue_rd] = 1'b1;
    end
    if (rf_wen) begin
      busy_next[rf_waddr] = 1'b0;
    end
  end

  // Scoreboard register; cleared on reset together with the write stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_mask <= '0;
    end else begin
      busy_mask <= busy_next;
    end
  end

endmodule

// File: tb/tb_ysyx_24100029_wb_scheduler.sv
// Self-checking bench for the writeback scheduler: directed scenarios plus a
// random phase, checked every cycle against a reference model whose expected
// register-file writes are queued at handshake time and popped at commit.
module tb_ysyx_24100029_wb_scheduler;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_rd = '0;
  logic        issue_ready;
  logic [3:0]  rs1_addr = '0;
  logic [3:0]  rs2_addr = '0;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] busy_mask;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         sb[$];
  int          cyc = 0;
  bit          started = 1'b0;
  int          ptr_m = 0;
  logic [15:0] busy_m = '0;
  logic [1:0]  last_grant = '0;

  ysyx_24100029_wb_scheduler_if wb ();

  ysyx_24100029_wb_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .wb          (wb),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy_mask   (busy_mask)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drive one cycle of requester and issue inputs, return just after the closing edge.
  task automatic applyStimulus(input logic [1:0] v, input logic [3:0] a0, input logic [31:0] d0,
                               input logic [3:0] a1, input logic [31:0] d1,
                               input logic iv, input logic [3:0] ird);
    wb.req_valid = v;
    wb.req_addr  = {a1, a0};
    wb.req_data  = {d1, d0};
    issue_valid  = iv;
    issue_rd     = ird;
    @(posedge clock);
    #1;
  endtask

  // Reference model: check outputs mid-cycle, then advance the model state.
  always @(negedge clock) begin
    logic [1:0]  eg;
    logic        exp_wen;
    logic        exp_ir;
    logic [3:0]  ga;
    logic [31:0] gd;
    logic [15:0] bn;
    logic [3:0]  clr_addr;
    int          c;
    int          gi;
    cyc++;
    eg = '0;
    gi = 0;
    for (int k = 0; k < 2; k++) begin
      c = (ptr_m + k) % 2;
      if (eg == 2'b00 && wb.req_valid[c]) begin
        eg[c] = 1'b1;
        gi    = c;
      end
    end
    exp_wen  = (sb.size() > 0) && (sb[0].cyc == cyc);
    exp_ir   = !busy_m[issue_rd] || (issue_rd == 4'd0);
    clr_addr = exp_wen ? sb[0].addr : 4'd0;
    if (started) begin
      checkOutput("req_ready", 64'(wb.req_ready), 64'(eg));
      checkOutput("rf_wen", 64'(rf_wen), 64'(exp_wen));
      if (exp_wen) begin
        checkOutput("rf_waddr", 64'(rf_waddr), 64'(sb[0].addr));
        checkOutput("rf_wdata", 64'(rf_wdata), 64'(sb[0].data));
      end
      checkOutput("busy_mask", 64'(busy_mask), 64'(busy_m));
      checkOutput("issue_ready", 64'(issue_ready), 64'(exp_ir));
      checkOutput("rs1_busy", 64'(rs1_busy), 64'(busy_m[rs1_addr] && rs1_addr != 4'd0));
      checkOutput("rs2_busy", 64'(rs2_busy), 64'(busy_m[rs2_addr] && rs2_addr != 4'd0));
    end
    if (exp_wen) sb.delete(0);
    if (reset) begin
      sb.delete();
      busy_m = '0;
      ptr_m  = 0;
    end else begin
      bn = busy_m;
      if (issue_valid && exp_ir && issue_rd != 4'd0) bn[issue_rd] = 1'b1;
      if (exp_wen) bn[clr_addr] = 1'b0;
      busy_m = bn;
      if (eg != 2'b00) begin
        ga = wb.req_addr[gi*4 +: 4];
        gd = wb.req_data[gi*32 +: 32];
        if (ga != 4'd0) sb.push_back('{addr: ga, data: gd, cyc: cyc + 1});
        ptr_m = (gi + 1) % 2;
      end
    end
    last_grant = eg;
  end

  // Directed scenarios, random traffic, then the summary.
  initial begin
    logic [1:0]  rv;
    logic [3:0]  ra [2];
    logic [31:0] rd [2];
    wb.req_valid = '0;
    wb.req_addr  = '0;
    wb.req_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_rf_wen", 64'(rf_wen), 64'd0);
    checkOutput("reset_rf_waddr", 64'(rf_waddr), 64'd0);
    checkOutput("reset_rf_wdata", 64'(rf_wdata), 64'd0);
    checkOutput("reset_busy_mask", 64'(busy_mask), 64'd0);
    started = 1'b1;
    reset   = 1'b0;
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0);

    $display("[TB] scenario 1: back-to-back round robin");
    applyStimulus(2'b11, 4'd5, 32'hA5, 4'd6, 32'h5A, 1'b0, 4'd0);
    checkOutput("t1_first_addr", 64'(rf_waddr), 64'd5);
    applyStimulus(2'b11, 4'd5, 32'hA5, 4'd6, 32'h5A, 1'b0, 4'd0);
    checkOutput("t1_second_addr", 64'(rf_waddr), 64'd6);
    checkOutput("t1_second_data", 64'(rf_wdata), 64'h5A);
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0);

    $display("[TB] scenario 2: RAW hazard window");
    rs1_addr = 4'd7;
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b1, 4'd7);
    checkOutput("t2_busy_set", 64'(rs1_busy), 64'd1);
    applyStimulus(2'b01, 4'd7, 32'h77, 4'd0, 32'h0, 1'b0, 4'd0);
    checkOutput("t2_busy_commit", 64'(rs1_busy), 64'd1);
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    checkOutput("t2_busy_dropped", 64'(rs1_busy), 64'd0);
    rs1_addr = 4'd0;

    $display("[TB] scenario 3: issue colliding with commit");
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    applyStimulus(2'b01, 4'd3, 32'h33, 4'd0, 32'h0, 1'b0, 4'd0);
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    checkOutput("t3_cleared", 64'(busy_mask[3]), 64'd0);
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b1, 4'd3);
    checkOutput("t3_reissued", 64'(busy_mask[3]), 64'd1);
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0);

    $display("[TB] scenario 4: write to x0");
    applyStimulus(2'b10, 4'd0, 32'h0, 4'd0, 32'hFFFF_FFFF, 1'b0, 4'd0);
    checkOutput("t4_no_wen", 64'(rf_wen), 64'd0);
    checkOutput("t4_mask", 64'(busy_mask), 64'h0008);

    $display("[TB] scenario 5: lone requester then contention");
    repeat (3) begin
      applyStimulus(2'b10, 4'd2, 32'h22, 4'd4, 32'h44, 1'b0, 4'd0);
      checkOutput("t5_grant1", 64'(rf_waddr), 64'd4);
    end
    applyStimulus(2'b11, 4'd2, 32'h22, 4'd4, 32'h44, 1'b0, 4'd0);
    checkOutput("t5_grant0_first", 64'(rf_waddr), 64'd2);
    applyStimulus(2'b10, 4'd0, 32'h0, 4'd4, 32'h44, 1'b0, 4'd0);
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0);

    $display("[TB] scenario 6: reset drops staged write");
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b1, 4'd9);
    reset = 1'b1;
    applyStimulus(2'b01, 4'd8, 32'h88, 4'd0, 32'h0, 1'b0, 4'd0);
    reset = 1'b0;
    checkOutput("t6_wen_a", 64'(rf_wen), 64'd0);
    checkOutput("t6_mask", 64'(busy_mask), 64'd0);
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    checkOutput("t6_wen_b", 64'(rf_wen), 64'd0);
    applyStimulus(2'b11, 4'd10, 32'hAA, 4'd11, 32'hBB, 1'b0, 4'd0);
    checkOutput("t6_ptr_zero", 64'(rf_waddr), 64'd10);
    applyStimulus(2'b10, 4'd0, 32'h0, 4'd11, 32'hBB, 1'b0, 4'd0);
    applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0);

    $display("[TB] random traffic");
    rv = '0;
    ra = '{4'd0, 4'd0};
    rd = '{32'd0, 32'd0};
    repeat (300) begin
      for (int i = 0; i < 2; i++) begin
        if (!(rv[i] && !last_grant[i])) begin
          rv[i] = 1'($urandom_range(0, 1));
          ra[i] = 4'($urandom_range(0, 15));
          rd[i] = $urandom;
        end
      end
      rs1_addr = 4'($urandom_range(0, 15));
      rs2_addr = 4'($urandom_range(0, 15));
      applyStimulus(rv, ra[0], rd[0], ra[1], rd[1], 1'($urandom_range(0, 1)),
                    4'($urandom_range(0, 15)));
    end
    repeat (3) applyStimulus(2'b00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
